// File: rtl/i2c_codec_responder_pkg.sv
// Shared definitions for the I2C codec responder: target address, the
// register address that clears the shadow bank, bank depth, FSM states.
package i2c_codec_responder_pkg;

  localparam logic [6:0] DEV_ADDR     = 7'h1A;
  localparam logic [6:0] RESET_REG    = 7'h0F;
  localparam int         SHADOW_DEPTH = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_B1,
    ST_ACK1,
    ST_B2,
    ST_ACK2,
    ST_WAIT_STOP,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_codec_responder_line_sync.sv
// Bus line conditioning for the responder.
//   clk_i, rst_ni        : system clock, async active-low reset
//   scl_i, sda_i         : raw bus lines
//   sda_o                : synchronized SDA
//   scl_rise_o/scl_fall_o: one-cycle SCL edge strobes
//   start_o/stop_o       : one-cycle START / STOP strobes
module i2c_line_sync
  import i2c_codec_responder_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0],[1] are the synchronizer stages, [2] is the previous synchronized sample.
  // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  logic scl_high_both;
  assign scl_high_both = scl_q[1] & scl_q[2];

  assign sda_o      = sda_q[1];
  assign scl_rise_o =  scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] &  scl_q[2];
  // SCL high in both samples already excludes an SCL edge this cycle.
  assign start_o    = scl_high_both & ~sda_q[1] &  sda_q[2];
  assign stop_o     = scl_high_both &  sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_codec_responder.sv
// I2C write-only responder standing in for a WM8731-style codec.
//   clk_i, rst_ni : system clock (>=16x SCL), async active-low reset
//   i2c_sclk_i    : bus clock;  i2c_sdat_io : open-drain data (0 or z only)
//   wr_strobe_o   : one-cycle pulse per committed write, with wr_addr_o/wr_data_o
//   xfer_err_o    : one-cycle pulse when an addressed frame is cut short
//   busy_o        : high from address match until STOP
//   rd_addr_i/rd_data_o : combinational read of the 16x9 shadow bank
//
// state        | meaning
// ST_IDLE      | bus free or not addressed yet
// ST_DEV       | shifting device byte
// ST_DEV_ACK   | driving ACK for device byte
// ST_B1        | shifting reg[6:0],data[8]
// ST_ACK1      | driving ACK for B1
// ST_B2        | shifting data[7:0]
// ST_ACK2      | driving ACK for B2, write committed on entry
// ST_WAIT_STOP | frame done, further bytes NACKed
// ST_IGNORE    | other target or read request, stay silent
module i2c_codec_responder
  import i2c_codec_responder_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       i2c_sclk_i,
  inout  wire        i2c_sdat_io,
  output logic       wr_strobe_o,
  output logic [6:0] wr_addr_o,
  output logic [8:0] wr_data_o,
  output logic       xfer_err_o,
  output logic       busy_o,
  input  logic [3:0] rd_addr_i,
  output logic [8:0] rd_data_o
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (i2c_sclk_i),
    .sda_i      (i2c_sdat_io),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] b1_q, b1_d;
  logic       sda_low_q, sda_low_d;
  logic       strobe_q, strobe_d;
  logic [6:0] addr_q, addr_d;
  logic [8:0] data_q, data_d;
  logic       err_q, err_d;
  logic [8:0] shadow_q [SHADOW_DEPTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    b1_d      = b1_q;
    sda_low_d = sda_low_q;
    strobe_d  = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = 1'b0;

    if (scl_rise && (state_q == ST_DEV || state_q == ST_B1 || state_q == ST_B2)) begin
      shift_d = {shift_q[6:0], sda_s};
      cnt_d   = cnt_q + 4'd1;
    end

    // Byte decisions happen on the falling edge after bit 8, which is also
    // where the ACK window opens; the next falling edge closes it.
    if (scl_fall) begin
      case (state_q)
        ST_DEV: if (cnt_q == 4'd8) begin
          cnt_d = '0;
          if (shift_q == {DEV_ADDR, 1'b0}) begin
            state_d   = ST_DEV_ACK;
            sda_low_d = 1'b1;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_B1: if (cnt_q == 4'd8) begin
          cnt_d     = '0;
          b1_d      = shift_q;
          state_d   = ST_ACK1;
          sda_low_d = 1'b1;
        end
        ST_B2: if (cnt_q == 4'd8) begin
          cnt_d     = '0;
          state_d   = ST_ACK2;
          sda_low_d = 1'b1;
          strobe_d  = 1'b1;
          addr_d    = b1_q[7:1];
          data_d    = {b1_q[0], shift_q};
        end
        ST_DEV_ACK: begin sda_low_d = 1'b0; state_d = ST_B1;        end
        ST_ACK1:    begin sda_low_d = 1'b0; state_d = ST_B2;        end
        ST_ACK2:    begin sda_low_d = 1'b0; state_d = ST_WAIT_STOP; end
        default: ;
      endcase
    end

    if (start_det || stop_det) begin
      if (state_q == ST_DEV_ACK || state_q == ST_B1 ||
          state_q == ST_ACK1    || state_q == ST_B2) begin
        err_d = 1'b1;
      end
      sda_low_d = 1'b0;
      cnt_d     = '0;
      state_d   = start_det ? ST_DEV : ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      b1_q      <= '0;
      sda_low_q <= 1'b0;
      strobe_q  <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      b1_q      <= b1_d;
      sda_low_q <= sda_low_d;
      strobe_q  <= strobe_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      err_q     <= err_d;
    end
  end

  // Bank is written from the registered write, so reads see it the cycle
  // after the strobe. RESET_REG lies inside the bank, so test it first.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SHADOW_DEPTH; i++) shadow_q[i] <= '0;
    end else if (strobe_q) begin
      if (addr_q == RESET_REG) begin
        for (int i = 0; i < SHADOW_DEPTH; i++) shadow_q[i] <= '0;
      end else if (addr_q < 7'(SHADOW_DEPTH)) begin
        shadow_q[addr_q[3:0]] <= data_q;
      end
    end
  end

  assign i2c_sdat_io = sda_low_q ? 1'b0 : 1'bz;
  assign wr_strobe_o = strobe_q;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign xfer_err_o  = err_q;
  assign busy_o      = (state_q == ST_DEV_ACK) || (state_q == ST_B1) ||
                       (state_q == ST_ACK1)    || (state_q == ST_B2) ||
                       (state_q == ST_ACK2)    || (state_q == ST_WAIT_STOP);
  assign rd_data_o   = shadow_q[rd_addr_i];

endmodule

// File: tb/tb_i2c_codec_responder.sv
module tb_i2c_codec_responder;

  localparam int Q = 160;  // quarter SCL period in ns (8 system clocks)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       tb_low = 1'b0;
  logic [3:0] rd_addr = '0;

  wire        sda;
  logic       wr_strobe, xfer_err, busy;
  logic [6:0] wr_addr;
  logic [8:0] wr_data, rd_data;

  pullup (sda);
  assign sda = tb_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  i2c_codec_responder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .i2c_sclk_i  (scl),
    .i2c_sdat_io (sda),
    .wr_strobe_o (wr_strobe),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .xfer_err_o  (xfer_err),
    .busy_o      (busy),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data)
  );

  typedef struct packed {
    logic [6:0] a;
    logic [8:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail = 0;
  int  strobe_cnt = 0;
  int  err_cnt = 0;
  bit  busy_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every strobe pops one expected write.
  always @(negedge clk) begin
    if (busy) busy_seen = 1'b1;
    if (xfer_err) err_cnt++;
    if (wr_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_strobe: observed addr=0x%0h data=0x%0h expected no strobe",
               wr_addr, wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {25'd0, wr_addr}, {25'd0, mon_e.a});
        check("wr_data", {23'd0, wr_data}, {23'd0, mon_e.d});
      end
    end
  end

  task automatic bit_out(input logic b);
    tb_low = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic ack_in(output logic ack);
    tb_low = 1'b0;
    #Q scl = 1'b1;
    #Q ack = (sda === 1'b0);
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    ack_in(ack);
  endtask

  task automatic i2c_start();
    tb_low = 1'b0;
    #Q scl = 1'b1;
    #Q tb_low = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    tb_low = 1'b1;
    #Q scl = 1'b1;
    #Q tb_low = 1'b0;
    #(2*Q);
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       output logic [2:0] acks);
    i2c_start();
    send_byte(a, acks[2]);
    send_byte(b, acks[1]);
    send_byte(c, acks[0]);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [8:0] exp);
    rd_addr = a;
    #1;
    check(tag, {23'd0, rd_data}, {23'd0, exp});
  endtask

  logic [2:0] acks;
  logic       ack4;
  int         s0, e0;

  initial begin
    repeat (4) @(negedge clk);
    check("rst_sda", {31'd0, sda}, 32'd1);
    check("rst_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_addr", {25'd0, wr_addr}, 32'd0);
    check("rst_data", {23'd0, wr_data}, 32'd0);
    check("rst_err", {31'd0, xfer_err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 16; i++) rd_check("rst_shadow", 4'(i), 9'h000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Basic write: reg 2 <= 0x012
    s0 = strobe_cnt; e0 = err_cnt;
    exp_q.push_back('{a: 7'h02, d: 9'h012});
    frame(8'h34, 8'h04, 8'h12, acks);
    check("t1_busy_in_frame", {31'd0, busy}, 32'd1);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t1_acks", {29'd0, acks}, 32'h7);
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
    check("t1_strobes", strobe_cnt - s0, 32'd1);
    check("t1_err", err_cnt - e0, 32'd0);
    rd_check("t1_rd2", 4'd2, 9'h012);

    // Wrong address and read request: silent
    for (int k = 0; k < 2; k++) begin
      s0 = strobe_cnt;
      busy_seen = 1'b0;
      frame((k == 0) ? 8'h36 : 8'h35, 8'h04, 8'h12, acks);
      i2c_stop();
      repeat (4) @(negedge clk);
      check("t2_acks", {29'd0, acks}, 32'h0);
      check("t2_strobes", strobe_cnt - s0, 32'd0);
      check("t2_busy_seen", {31'd0, busy_seen}, 32'd0);
    end

    // Truncated frame: STOP while in B2
    s0 = strobe_cnt; e0 = err_cnt;
    i2c_start();
    send_byte(8'h34, acks[2]);
    send_byte(8'h04, acks[1]);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t3_acks", {30'd0, acks[2:1]}, 32'h3);
    check("t3_err", err_cnt - e0, 32'd1);
    check("t3_strobes", strobe_cnt - s0, 32'd0);
    rd_check("t3_rd2", 4'd2, 9'h012);

    // Populate reg 5 with data bit 8 set, then a write above the bank
    exp_q.push_back('{a: 7'h05, d: 9'h1AB});
    frame(8'h34, 8'h0B, 8'hAB, acks);
    i2c_stop();
    repeat (4) @(negedge clk);
    rd_check("t4_rd5", 4'd5, 9'h1AB);
    s0 = strobe_cnt;
    exp_q.push_back('{a: 7'h20, d: 9'h055});
    frame(8'h34, 8'h40, 8'h55, acks);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t4_high_strobe", strobe_cnt - s0, 32'd1);
    rd_check("t4_rd0", 4'd0, 9'h000);

    // Aborted start, repeated START, then a write to the reset register
    s0 = strobe_cnt; e0 = err_cnt;
    i2c_start();
    bit_out(1'b1); bit_out(1'b0); bit_out(1'b1);
    exp_q.push_back('{a: 7'h0F, d: 9'h000});
    frame(8'h34, 8'h1E, 8'h00, acks);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t5_acks", {29'd0, acks}, 32'h7);
    check("t5_strobes", strobe_cnt - s0, 32'd1);
    check("t5_err", err_cnt - e0, 32'd0);
    for (int i = 0; i < 16; i++) rd_check("t5_cleared", 4'(i), 9'h000);

    // Extra fourth byte is NACKed
    s0 = strobe_cnt;
    exp_q.push_back('{a: 7'h03, d: 9'h077});
    frame(8'h34, 8'h06, 8'h77, acks);
    send_byte(8'hFF, ack4);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t6_acks", {29'd0, acks}, 32'h7);
    check("t6_ack4", {31'd0, ack4}, 32'd0);
    check("t6_strobes", strobe_cnt - s0, 32'd1);
    rd_check("t6_rd3", 4'd3, 9'h077);

    // Reset during ACK1
    i2c_start();
    send_byte(8'h34, acks[2]);
    for (int i = 7; i >= 0; i--) bit_out(i == 2);
    tb_low = 1'b0;
    #1;
    check("t7_ack1_driven", {31'd0, sda}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("t7_sda_released", {31'd0, sda}, 32'd1);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_strobe", {31'd0, wr_strobe}, 32'd0);
    check("t7_addr", {25'd0, wr_addr}, 32'd0);
    check("t7_data", {23'd0, wr_data}, 32'd0);
    check("t7_err", {31'd0, xfer_err}, 32'd0);
    rd_check("t7_rd3", 4'd3, 9'h000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    i2c_stop();
    repeat (4) @(negedge clk);
    s0 = strobe_cnt;
    exp_q.push_back('{a: 7'h04, d: 9'h099});
    frame(8'h34, 8'h08, 8'h99, acks);
    i2c_stop();
    repeat (4) @(negedge clk);
    check("t7_acks", {29'd0, acks}, 32'h7);
    check("t7_strobes", strobe_cnt - s0, 32'd1);
    rd_check("t7_rd4", 4'd4, 9'h099);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
